wb_retire_queue: RTL and testbench

- Dual-lane writeback queue. It sits between the two execution lanes and the dual-write-port register file of the superscalar core.
- Accepts up to two results per cycle in program order and buffers them in a circular queue.
- Drains up to two results per cycle onto the register-file write ports, using the ports' write-code convention: 4'd2 = write, 4'd0 = idle.
- When two drained results target the same register, it ensures the younger result is the one that lands.

---
 rtl/wb_retire_queue.sv | 122 ++++++++++++
 tb/tb_wb_retire_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - dual-lane in-order writeback queue feeding a dual-write-port register file
module wb_retire_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in0_valid,
    input  logic [4:0]    in0_rd,
    input  logic [31:0]   in0_data,
    input  logic [3:0]    in0_we,
    input  logic          in1_valid,
    input  logic [4:0]    in1_rd,
    input  logic [31:0]   in1_data,
    input  logic [3:0]    in1_we,
    output logic          in_ready,
    output logic [4:0]    rd1,
    output logic [31:0]   wb_data1,
    output logic [3:0]    wb_we1,
    output logic [4:0]    rd2,
    output logic [31:0]   wb_data2,
    output logic [3:0]    wb_we2,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  we;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail1, head1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    push_n, pop_n;

    logic [4:0]    rd1_q, rd1_d, rd2_q, rd2_d;
    logic [31:0]   data1_q, data1_d, data2_q, data2_d;
    logic [3:0]    we1_q, we1_d, we2_q, we2_d;

    entry_t        older, younger;
    logic          older_wr, younger_wr, same_dest;

    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign count    = count_q;
    assign rd1      = rd1_q;
    assign wb_data1 = data1_q;
    assign wb_we1   = we1_q;
    assign rd2      = rd2_q;
    assign wb_data2 = data2_q;
    assign wb_we2   = we2_q;

    assign tail1   = tail_q + PW'(1);
    assign head1   = head_q + PW'(1);
    assign older   = mem_q[head_q];
    assign younger = mem_q[head1];

    // Only a real write code to a nonzero register may reach the register file.
    assign older_wr   = (older.we == 4'd2) && (older.rd != 5'd0);
    assign younger_wr = (younger.we == 4'd2) && (younger.rd != 5'd0);
    assign same_dest  = older_wr && younger_wr && (older.rd == younger.rd);

    always_comb begin
        push_n  = in_ready ? ({1'b0, in0_valid} + {1'b0, in1_valid}) : 2'd0;
        pop_n   = (count_q >= CW'(2)) ? 2'd2 : ((count_q == CW'(1)) ? 2'd1 : 2'd0);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        head_d  = head_q + PW'(pop_n);
        tail_d  = tail_q + PW'(push_n);

        rd1_d   = 5'd0;
        data1_d = 32'd0;
        we1_d   = 4'd0;
        rd2_d   = 5'd0;
        data2_d = 32'd0;
        we2_d   = 4'd0;
        if (pop_n != 2'd0) begin
            rd2_d   = older.rd;
            data2_d = older.data;
            we2_d   = (older_wr && !(pop_n == 2'd2 && same_dest)) ? 4'd2 : 4'd0;
        end
        if (pop_n == 2'd2) begin
            rd1_d   = younger.rd;
            data1_d = younger.data;
            we1_d   = younger_wr ? 4'd2 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rd1_q   <= 5'd0;
            data1_q <= 32'd0;
            we1_q   <= 4'd0;
            rd2_q   <= 5'd0;
            data2_q <= 32'd0;
            we2_q   <= 4'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rd1_q   <= rd1_d;
            data1_q <= data1_d;
            we1_q   <= we1_d;
            rd2_q   <= rd2_d;
            data2_q <= data2_d;
            we2_q   <= we2_d;
        end
    end

    // A lone lane-1 result takes the tail slot so program order stays gap-free.
    always_ff @(posedge clk) begin
        if (in_ready) begin
            if (in0_valid)
                mem_q[tail_q] <= '{rd: in0_rd, data: in0_data, we: in0_we};
            if (in1_valid)
                mem_q[in0_valid ? tail1 : tail_q] <= '{rd: in1_rd, data: in1_data, we: in1_we};
        end
    end
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - self-checking bench for wb_retire_queue
module tb_wb_retire_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in0_valid, in1_valid;
    logic [4:0]    in0_rd, in1_rd;
    logic [31:0]   in0_data, in1_data;
    logic [3:0]    in0_we, in1_we;
    logic          in_ready;
    logic [4:0]    rd1, rd2;
    logic [31:0]   wb_data1, wb_data2;
    logic [3:0]    wb_we1, wb_we2;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    wb_retire_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_rd(in0_rd), .in0_data(in0_data), .in0_we(in0_we),
        .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data), .in1_we(in1_we),
        .in_ready(in_ready),
        .rd1(rd1), .wb_data1(wb_data1), .wb_we1(wb_we1),
        .rd2(rd2), .wb_data2(wb_data2), .wb_we2(wb_we2),
        .count(count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  we;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [3:0]  w0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic [3:0]  w1;
        logic [3:0]  e_we1;
        logic        p1;
        logic [4:0]  e_rd1;
        logic [31:0] e_d1;
        logic [3:0]  e_we2;
        logic [4:0]  e_rd2;
        logic [31:0] e_d2;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] rf_exp[32] = '{default: 32'd0};
    logic [31:0] rf_dut[32] = '{default: 32'd0};
    int          wr_cnt = 0;
    int          pass_cnt = 0;
    int          total = 0;
    vec_t        tv[6];

    // Register-file view of the write ports: port 1 lands last so it wins.
    always @(posedge clk) begin
        if (wb_we2 == 4'd2) rf_dut[rd2] <= wb_data2;
        if (wb_we1 == 4'd2) rf_dut[rd1] <= wb_data1;
        wr_cnt <= wr_cnt + ((wb_we1 == 4'd2) ? 1 : 0) + ((wb_we2 == 4'd2) ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic writes(input ent_t e);
        return (e.we == 4'd2) && (e.rd != 5'd0);
    endfunction

    task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0, input logic [3:0] w0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1, input logic [3:0] w1,
                        input string tag);
        int   npop;
        ent_t o, y;
        logic [3:0] e1, e2;
        logic exp_rdy;
        in0_valid = v0; in0_rd = r0; in0_data = d0; in0_we = w0;
        in1_valid = v1; in1_rd = r1; in1_data = d1; in1_we = w1;
        exp_rdy = (DEPTH - mq.size()) >= 2;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        npop = (mq.size() >= 2) ? 2 : mq.size();
        o = '{rd: 5'd0, data: 32'd0, we: 4'd0};
        y = o;
        if (npop >= 1) o = mq.pop_front();
        if (npop == 2) y = mq.pop_front();
        e1 = (npop == 2 && writes(y)) ? 4'd2 : 4'd0;
        e2 = (npop >= 1 && writes(o) && !(e1 == 4'd2 && o.rd == y.rd)) ? 4'd2 : 4'd0;
        if (npop >= 1 && writes(o)) rf_exp[o.rd] = o.data;
        if (npop == 2 && writes(y)) rf_exp[y.rd] = y.data;
        if (exp_rdy) begin
            if (v0) mq.push_back('{rd: r0, data: d0, we: w0});
            if (v1) mq.push_back('{rd: r1, data: d1, we: w1});
        end
        @(posedge clk);
        #1;
        chk({tag, " wb_we2"}, 32'(wb_we2), 32'(e2));
        chk({tag, " wb_we1"}, 32'(wb_we1), 32'(e1));
        if (npop >= 1) begin
            chk({tag, " rd2"}, 32'(rd2), 32'(o.rd));
            chk({tag, " wb_data2"}, wb_data2, o.data);
        end
        if (npop == 2) begin
            chk({tag, " rd1"}, 32'(rd1), 32'(y.rd));
            chk({tag, " wb_data1"}, wb_data1, y.data);
        end
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, tag);
    endtask

    initial begin
        int base;
        tv[0] = '{1'b1, 5'd5, 32'h11, 4'd2, 1'b1, 5'd6, 32'h22, 4'd2, 4'd2, 1'b1, 5'd6, 32'h22, 4'd2, 5'd5, 32'h11};
        tv[1] = '{1'b1, 5'd7, 32'hAA, 4'd2, 1'b1, 5'd7, 32'hBB, 4'd2, 4'd2, 1'b1, 5'd7, 32'hBB, 4'd0, 5'd7, 32'hAA};
        tv[2] = '{1'b1, 5'd0, 32'h5,  4'd2, 1'b1, 5'd3, 32'h9,  4'd0, 4'd0, 1'b1, 5'd3, 32'h9,  4'd0, 5'd0, 32'h5};
        tv[3] = '{1'b1, 5'd9, 32'h99, 4'd2, 1'b0, 5'd0, 32'h0,  4'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd2, 5'd9, 32'h99};
        tv[4] = '{1'b0, 5'd0, 32'h0,  4'd0, 1'b1, 5'd10, 32'hA0, 4'd2, 4'd0, 1'b0, 5'd0, 32'h0, 4'd2, 5'd10, 32'hA0};
        tv[5] = '{1'b1, 5'd4, 32'h44, 4'd3, 1'b1, 5'd4, 32'h45, 4'd2, 4'd2, 1'b1, 5'd4, 32'h45, 4'd0, 5'd4, 32'h44};

        reset_n = 1'b0;
        in0_valid = 1'b1; in0_rd = 5'd5; in0_data = 32'hFF; in0_we = 4'd2;
        in1_valid = 1'b0; in1_rd = 5'd0; in1_data = 32'd0;  in1_we = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset wb_we1", 32'(wb_we1), 32'd0);
        chk("reset wb_we2", 32'(wb_we2), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        in0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset rd2", 32'(rd2), 32'd0);
        chk("post-reset wb_data2", wb_data2, 32'd0);
        chk("post-reset wb_we2", 32'(wb_we2), 32'd0);

        for (int i = 0; i < 6; i++) begin
            step(tv[i].v0, tv[i].r0, tv[i].d0, tv[i].w0, tv[i].v1, tv[i].r1, tv[i].d1, tv[i].w1, "vec push");
            idle("vec drain");
            chk($sformatf("vec%0d wb_we1", i), 32'(wb_we1), 32'(tv[i].e_we1));
            chk($sformatf("vec%0d wb_we2", i), 32'(wb_we2), 32'(tv[i].e_we2));
            chk($sformatf("vec%0d rd2", i), 32'(rd2), 32'(tv[i].e_rd2));
            chk($sformatf("vec%0d wb_data2", i), wb_data2, tv[i].e_d2);
            if (tv[i].p1) begin
                chk($sformatf("vec%0d rd1", i), 32'(rd1), 32'(tv[i].e_rd1));
                chk($sformatf("vec%0d wb_data1", i), wb_data1, tv[i].e_d1);
            end
            idle("vec settle");
            chk($sformatf("vec%0d count", i), 32'(count), 32'd0);
        end
        chk("same-dest rf x7", rf_dut[7], 32'hBB);

        step(1'b1, 5'd1, 32'd1, 4'd2, 1'b0, 5'd0, 32'd0, 4'd0, "seq x1");
        step(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd2, 32'd2, 4'd2, "seq x2");
        chk("seq1 rd2", 32'(rd2), 32'd1);
        chk("seq1 wb_data2", wb_data2, 32'd1);
        chk("seq1 wb_we1", 32'(wb_we1), 32'd0);
        idle("seq drain");
        chk("seq2 rd2", 32'(rd2), 32'd2);
        chk("seq2 wb_data2", wb_data2, 32'd2);
        chk("seq2 wb_we2", 32'(wb_we2), 32'd2);
        chk("seq2 wb_we1", 32'(wb_we1), 32'd0);
        idle("seq settle");

        // Ten back-to-back pairs walk the pointers past the wrap point.
        base = wr_cnt;
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'((2 * i) % 31 + 1), 32'h1000 + 32'(2 * i), 4'd2,
                 1'b1, 5'((2 * i + 1) % 31 + 1), 32'h1000 + 32'(2 * i + 1), 4'd2, "wrap");
        repeat (3) idle("wrap drain");
        chk("wrap write count", 32'(wr_cnt - base), 32'd20);

        step(1'b1, 5'd11, 32'hDEAD, 4'd2, 1'b1, 5'd12, 32'hBEEF, 4'd2, "midreset push");
        reset_n = 1'b0;
        #1;
        chk("midreset wb_we1", 32'(wb_we1), 32'd0);
        chk("midreset wb_we2", 32'(wb_we2), 32'd0);
        chk("midreset count", 32'(count), 32'd0);
        mq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle("midreset after");
        chk("midreset rf x11", rf_dut[11], rf_exp[11]);

        for (int i = 0; i < 300; i++) begin
            logic v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            step(v0, 5'($urandom_range(0, 7)), $urandom, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 2),
                 v1, 5'($urandom_range(0, 7)), $urandom, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 2),
                 "rand");
        end
        repeat (3) idle("rand drain");
        for (int r = 1; r < 32; r++)
            chk($sformatf("final rf x%0d", r), rf_dut[r], rf_exp[r]);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
